// File: rtl/eth_rx_pkg.sv
// Shared constants, status codes and FSM encoding for the Ethernet receive path.
// Also provides the end-of-frame status decision.
package eth_rx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef logic [1:0] rx_status_t;

    localparam rx_status_t ST_GOOD = 2'd0;
    localparam rx_status_t ST_FCS  = 2'd1;
    localparam rx_status_t ST_RUNT = 2'd2;
    localparam rx_status_t ST_LONG = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } rx_state_e;

    // Runt outranks FCS/rx_er errors; the CRC register holds the residue when the FCS is intact.
    function automatic rx_status_t end_status(input logic runt, input logic er_seen,
                                              input logic [31:0] crc);
        if (runt)
            return ST_RUNT;
        if (er_seen || (crc != CRC_RESIDUE))
            return ST_FCS;
        return ST_GOOD;
    endfunction

endpackage

// File: rtl/eth_rx_if.sv
// PHY receive byte lane plus the outgoing frame stream and per-frame completion status.
// master drives the PHY side and consumes the stream; slave is the receiver.
interface eth_rx_if #(
    parameter int LEN_W = 11
) ();
    import eth_rx_pkg::*;

    logic [7:0]       rx_data;
    logic [1:0]       rx_ctl;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_sof;
    logic             frame_done;
    rx_status_t       frame_status;
    logic [LEN_W-1:0] frame_len;

    modport master (
        output rx_data, rx_ctl,
        input  out_data, out_valid, out_sof, frame_done, frame_status, frame_len
    );

    modport slave (
        input  rx_data, rx_ctl,
        output out_data, out_valid, out_sof, frame_done, frame_status, frame_len
    );

endinterface

// File: rtl/crc32_byte_update.sv
// Combinational reflected CRC-32 (poly EDB88320) advance by one byte, data LSB first.
// No state, no latency; shared with the transmit-side FCS generator.
module crc32_byte_update
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/eth_packet_receiver.sv
// RGMII receive framer: strips preamble/SFD/FCS, checks CRC, length and rx_er, streams frame bytes.
// Latency: byte n out 2 cycles after byte n+4 arrives; no backpressure, the stream cannot stall.
module eth_packet_receiver
    import eth_rx_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int LEN_W   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    eth_rx_if.slave     rx_bus,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
);

    localparam logic [LEN_W-1:0] FCS_BYTES = LEN_W'(4);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);

    logic [7:0]       data_q;
    logic             dv_q;
    logic             er_q;
    rx_state_e        state;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [LEN_W-1:0] len;
    logic             er_flag;
    logic [3:0][7:0]  dly;
    rx_status_t       done_status;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
        end else begin
            data_q <= rx_bus.rx_data;
            dv_q   <= rx_bus.rx_ctl[0];
            er_q   <= rx_bus.rx_ctl[0] ^ rx_bus.rx_ctl[1];
        end
    end

    crc32_byte_update u_crc (
        .crc      (crc),
        .data     (data_q),
        .crc_next (crc_next)
    );

    assign done_status = end_status(len < MIN_L, er_flag, crc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            crc                 <= CRC_INIT;
            len                 <= '0;
            er_flag             <= 1'b0;
            dly                 <= '0;
            rx_bus.out_data     <= '0;
            rx_bus.out_valid    <= 1'b0;
            rx_bus.out_sof      <= 1'b0;
            rx_bus.frame_done   <= 1'b0;
            rx_bus.frame_status <= ST_GOOD;
            rx_bus.frame_len    <= '0;
            good_count          <= '0;
            bad_count           <= '0;
        end else begin
            rx_bus.out_valid  <= 1'b0;
            rx_bus.out_sof    <= 1'b0;
            rx_bus.frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dv_q)
                        state <= (enable && data_q == PREAMBLE_BYTE) ? S_PREAMBLE : S_DROP;
                end
                S_PREAMBLE: begin
                    if (!dv_q) begin
                        state <= S_IDLE;
                    end else if (data_q == SFD_BYTE) begin
                        state   <= S_DATA;
                        crc     <= CRC_INIT;
                        len     <= '0;
                        er_flag <= 1'b0;
                    end else if (data_q != PREAMBLE_BYTE) begin
                        state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (!dv_q) begin
                        state               <= S_IDLE;
                        rx_bus.frame_done   <= 1'b1;
                        rx_bus.frame_status <= done_status;
                        rx_bus.frame_len    <= (len >= FCS_BYTES) ? len - FCS_BYTES : '0;
                        if (done_status == ST_GOOD)
                            good_count <= good_count + 16'd1;
                        else
                            bad_count <= bad_count + 16'd1;
                    end else if (len == MAX_L) begin
                        // This byte would be number MAX_LEN+1: abandon without emitting it.
                        state               <= S_DROP;
                        rx_bus.frame_done   <= 1'b1;
                        rx_bus.frame_status <= ST_LONG;
                        rx_bus.frame_len    <= MAX_L - FCS_BYTES;
                        bad_count           <= bad_count + 16'd1;
                    end else begin
                        crc <= crc_next;
                        len <= len + LEN_W'(1);
                        dly <= {dly[2:0], data_q};
                        if (er_q)
                            er_flag <= 1'b1;
                        // Four-byte lag keeps the FCS off the stream.
                        if (len >= FCS_BYTES) begin
                            rx_bus.out_valid <= 1'b1;
                            rx_bus.out_data  <= dly[3];
                            rx_bus.out_sof   <= (len == FCS_BYTES);
                        end
                    end
                end
                S_DROP: begin
                    if (!dv_q)
                        state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_packet_receiver.sv
// Directed and randomized frames against a frame-level reference model and scoreboard.
module tb_eth_packet_receiver;
    import eth_rx_pkg::*;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;
    localparam int LEN_W   = 11;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] good_count;
    logic [15:0] bad_count;

    eth_rx_if #(.LEN_W(LEN_W)) bus ();

    eth_packet_receiver #(
        .MAX_LEN (MAX_LEN),
        .MIN_LEN (MIN_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rx_bus     (bus),
        .good_count (good_count),
        .bad_count  (bad_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  frm [0:2047];
    int          frm_n;
    logic [8:0]  exp_bytes[$], act_bytes[$];
    logic [12:0] exp_done[$], act_done[$];
    int          exp_done_cyc[$], act_done_cyc[$];
    int          exp_sof_cyc[$], act_sof_cyc[$];
    int          exp_good = 0;
    int          exp_bad  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid)
                act_bytes.push_back({bus.out_sof, bus.out_data});
            if (bus.out_valid && bus.out_sof)
                act_sof_cyc.push_back(cyc);
            if (bus.frame_done) begin
                act_done.push_back({bus.frame_status, bus.frame_len});
                act_done_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Standard Ethernet FCS over frm[0..n-1].
    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int plen, input bit rnd);
        logic [31:0] fcs;
        for (int i = 0; i < plen; i++)
            frm[i] = rnd ? 8'($urandom) : 8'(i);
        fcs = crc_ref(plen);
        for (int k = 0; k < 4; k++)
            frm[plen + k] = fcs[8*k +: 8];
        frm_n = plen + 4;
    endtask

    // Expected stream, status and length of the frame currently in frm.
    task automatic model(input int er_at);
        int          n;
        int          nout;
        int          flen;
        logic [1:0]  st;
        logic [31:0] fcs_rx;
        n = frm_n;
        if (n > MAX_LEN) begin
            nout = MAX_LEN - 4;
            flen = MAX_LEN - 4;
            st   = 2'd3;
        end else begin
            nout   = (n > 4) ? n - 4 : 0;
            flen   = nout;
            fcs_rx = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
            if (n < MIN_LEN)
                st = 2'd2;
            else if ((er_at >= 0 && er_at < n) || crc_ref(n - 4) != fcs_rx)
                st = 2'd1;
            else
                st = 2'd0;
        end
        for (int i = 0; i < nout; i++)
            exp_bytes.push_back({i == 0, frm[i]});
        exp_done.push_back({st, 11'(flen)});
        if (st == 2'd0)
            exp_good++;
        else
            exp_bad++;
    endtask

    // rx_ctl[1] carries dv^er, so an errored data byte is 2'b01 and a clean one 2'b11.
    task automatic send(input int er_at, input int en_off_at, input int rst_at,
                        input int gap, input bit modeled);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.rx_data = (i == 7) ? SFD_BYTE : PREAMBLE_BYTE;
            bus.rx_ctl  = 2'b11;
        end
        for (int i = 0; i < frm_n; i++) begin
            @(negedge clk);
            if (reset)
                reset = 1'b0;
            bus.rx_data = frm[i];
            bus.rx_ctl  = (i == er_at) ? 2'b01 : 2'b11;
            if (i == en_off_at)
                enable = 1'b0;
            if (modeled && i == 4)
                exp_sof_cyc.push_back(cyc + 2);
            if (modeled && i == MAX_LEN)
                exp_done_cyc.push_back(cyc + 2);
            if (i == rst_at) begin
                reset = 1'b1;
                #2;
                chk("rst_mid_ctl", {bus.out_valid, bus.out_sof, bus.frame_done}, 0);
                chk("rst_mid_data", bus.out_data, 0);
                chk("rst_mid_status_len", {bus.frame_status, bus.frame_len}, 0);
                chk("rst_mid_counts", {good_count, bad_count}, 0);
                act_bytes.delete();
                act_sof_cyc.delete();
                act_done.delete();
                act_done_cyc.delete();
                exp_good = 0;
                exp_bad  = 0;
            end
        end
        @(negedge clk);
        bus.rx_ctl  = 2'b00;
        bus.rx_data = 8'h00;
        if (modeled && frm_n <= MAX_LEN)
            exp_done_cyc.push_back(cyc + 2);
        repeat (gap - 1) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic check_phase(input string ph);
        int nbad = 0;
        repeat (6) @(negedge clk);
        chk({ph, ".byte_count"}, act_bytes.size(), exp_bytes.size());
        for (int i = 0; i < act_bytes.size() && i < exp_bytes.size(); i++)
            if (act_bytes[i] !== exp_bytes[i])
                nbad++;
        chk({ph, ".byte_mismatches"}, nbad, 0);
        chk({ph, ".done_count"}, act_done.size(), exp_done.size());
        for (int i = 0; i < act_done.size() && i < exp_done.size(); i++)
            chk({ph, ".done_status_len"}, act_done[i], exp_done[i]);
        chk({ph, ".done_cyc_count"}, act_done_cyc.size(), exp_done_cyc.size());
        for (int i = 0; i < act_done_cyc.size() && i < exp_done_cyc.size(); i++)
            chk({ph, ".done_latency"}, act_done_cyc[i], exp_done_cyc[i]);
        chk({ph, ".sof_count"}, act_sof_cyc.size(), exp_sof_cyc.size());
        for (int i = 0; i < act_sof_cyc.size() && i < exp_sof_cyc.size(); i++)
            chk({ph, ".sof_latency"}, act_sof_cyc[i], exp_sof_cyc[i]);
        chk({ph, ".good_count"}, good_count, exp_good);
        chk({ph, ".bad_count"}, bad_count, exp_bad);
        exp_bytes.delete();    act_bytes.delete();
        exp_done.delete();     act_done.delete();
        exp_done_cyc.delete(); act_done_cyc.delete();
        exp_sof_cyc.delete();  act_sof_cyc.delete();
    endtask

    initial begin
        int plen;
        int kind;
        int er;
        bus.rx_data = 8'h00;
        bus.rx_ctl  = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset.ctl", {bus.out_valid, bus.out_sof, bus.frame_done}, 0);
        chk("reset.data", bus.out_data, 0);
        chk("reset.status_len", {bus.frame_status, bus.frame_len}, 0);
        chk("reset.good_count", good_count, 0);
        chk("reset.bad_count", bad_count, 0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        build(60, 1'b0); model(-1); send(-1, -1, -1, 3, 1'b1);
        check_phase("good");

        build(60, 1'b0); frm[10] ^= 8'h01; model(-1); send(-1, -1, -1, 3, 1'b1);
        check_phase("flip");

        build(60, 1'b0); model(20); send(20, -1, -1, 3, 1'b1);
        check_phase("rx_er");

        build(36, 1'b1); model(-1); send(-1, -1, -1, 3, 1'b1);
        check_phase("runt");

        build(1596, 1'b1); model(-1); send(-1, -1, -1, 3, 1'b1);
        check_phase("long");
        build(60, 1'b1); model(-1); send(-1, -1, -1, 3, 1'b1);
        check_phase("after_long");

        build(60, 1'b0); send(-1, -1, 30, 3, 1'b0);
        check_phase("reset_mid");

        enable = 1'b0;
        build(60, 1'b1); send(-1, -1, -1, 3, 1'b0);
        check_phase("enable_off");
        build(60, 1'b1); model(-1); send(-1, -1, -1, 3, 1'b1);
        check_phase("enable_on");

        build(80, 1'b1); model(-1); send(-1, 40, -1, 3, 1'b1);
        check_phase("enable_mid");

        for (int f = 0; f < 8; f++) begin
            plen = $urandom_range(30, 200);
            kind = $urandom_range(0, 2);
            er   = -1;
            build(plen, 1'b1);
            if (kind == 1)
                frm[$urandom_range(0, plen - 1)] ^= 8'(1 << $urandom_range(0, 7));
            if (kind == 2)
                er = $urandom_range(0, plen + 3);
            model(er);
            send(er, -1, -1, 1, 1'b1);
        end
        check_phase("random_b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
